// File: rtl/parser_pkg.sv
// parser_pkg: shared types and field layout for the packet header parser.
//   state_t         - parser FSM encoding (FREE, FETCH, MATCH, DONE)
//   LEN_W/TS_W/TL_W - per-header config field widths (length, tag start, tag length)
//   ent_*           - layout of a next-table entry {valid, tag, next_id}
//   id_in_range     - bounds check used for header IDs and table slots
package parser_pkg;

    typedef enum logic [1:0] {FREE, FETCH, MATCH, DONE} state_t;

    localparam int LEN_W       = 16;
    localparam int TS_W        = 16;
    localparam int TL_W        = 3;
    localparam int ENT_NID_LSB = 0;

    function automatic int ent_w(input int tag_w, input int hid_w);
        return 1 + tag_w + hid_w;
    endfunction

    function automatic int ent_tag_lsb(input int hid_w);
        return ENT_NID_LSB + hid_w;
    endfunction

    function automatic int ent_valid_bit(input int tag_w, input int hid_w);
        return ent_tag_lsb(hid_w) + tag_w;
    endfunction

    function automatic logic id_in_range(input int unsigned id, input int unsigned n);
        return id < n;
    endfunction

endpackage

// File: rtl/next_table_match.sv
// next_table_match: combinational priority matcher over one header's next-table.
//   entries_i - NEXT_TABLE_SIZE packed {valid, tag, next_id} entries, entry 0 in the LS slot
//   tag_i     - tag read from the packet
//   hit_o     - some valid entry carries tag_i
//   next_id_o - next_id of the lowest-index matching entry (0 on miss)
module next_table_match
    import parser_pkg::*;
#(
    parameter int NEXT_TABLE_SIZE = 4,
    parameter int TAG_W           = 16,
    parameter int HID_W           = 2
) (
    input  logic [NEXT_TABLE_SIZE*(1+TAG_W+HID_W)-1:0] entries_i,
    input  logic [TAG_W-1:0]                           tag_i,
    output logic                                       hit_o,
    output logic [HID_W-1:0]                           next_id_o
);

    localparam int ENT_W = ent_w(TAG_W, HID_W);
    localparam int VB    = ent_valid_bit(TAG_W, HID_W);
    localparam int TLSB  = ent_tag_lsb(HID_W);

    // Scan from the top down so the lowest matching index is written last and wins.
    always_comb begin
        hit_o     = 1'b0;
        next_id_o = '0;
        for (int i = NEXT_TABLE_SIZE - 1; i >= 0; i--) begin
            if (entries_i[i*ENT_W+VB] && entries_i[i*ENT_W+TLSB +: TAG_W] == tag_i) begin
                hit_o     = 1'b1;
                next_id_o = entries_i[i*ENT_W+ENT_NID_LSB +: HID_W];
            end
        end
    end

endmodule

// File: rtl/pkt_hdr_parser.sv
// pkt_hdr_parser: walks a header chain in packet memory using per-header next-tables.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start_i, pkt_addr_i   - level parse request and packet base address
//   mem_*                 - tag read port (ce/addr/width out, ack/data in)
//   ready_o               - result valid; parsed_hdrs_o (header 0 in MS slot), hdr_valid_o,
//                           pkt_end_o, err_o (header loop) hold until the next accept
//   mod_*                 - config write port, accepted only while idle; mod_ack_o pulses after
//   PARSER_STATS_EN       - when defined, adds saturating pkt_cnt_o / err_cnt_o counters
module pkt_hdr_parser
    import parser_pkg::*;
#(
    parameter int NUM_HEADERS     = 4,
    parameter int NEXT_TABLE_SIZE = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int TAG_W           = 16,
    parameter int HID_W           = $clog2(NUM_HEADERS),
    parameter int IDX_W           = $clog2(NEXT_TABLE_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             pkt_addr_i,
    output logic                          mem_ce_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [3:0]                    mem_width_o,
    input  logic                          mem_ack_i,
    input  logic [DATA_W-1:0]             mem_data_i,
    output logic                          ready_o,
    output logic [NUM_HEADERS*ADDR_W-1:0] parsed_hdrs_o,
    output logic [NUM_HEADERS-1:0]        hdr_valid_o,
    output logic [ADDR_W-1:0]             pkt_end_o,
    output logic                          err_o,
    input  logic                          mod_start_i,
    input  logic [HID_W-1:0]              mod_hdr_id_i,
    input  logic [15:0]                   mod_hdr_len_i,
    input  logic [15:0]                   mod_tag_start_i,
    input  logic [2:0]                    mod_tag_len_i,
    input  logic [IDX_W-1:0]              mod_entry_idx_i,
    input  logic [1+TAG_W+HID_W-1:0]      mod_entry_i,
    output logic                          mod_ack_o
`ifdef PARSER_STATS_EN
    ,
    output logic [31:0]                   pkt_cnt_o,
    output logic [31:0]                   err_cnt_o
`endif
);

    localparam int ENT_W = ent_w(TAG_W, HID_W);
    localparam int TBL_W = NEXT_TABLE_SIZE * ENT_W;

    state_t                             state_q, state_d;
    logic [HID_W-1:0]                   cur_id_q, cur_id_d;
    logic [ADDR_W-1:0]                  cur_addr_q, cur_addr_d;
    logic [TAG_W-1:0]                   tag_q, tag_d;
    logic                               ready_q, ready_d;
    logic                               err_q, err_d;
    logic                               mod_ack_q, mod_ack_d;
    logic [NUM_HEADERS-1:0]             hdr_valid_q, hdr_valid_d;
    logic [NUM_HEADERS-1:0][ADDR_W-1:0] parsed_q, parsed_d;
    logic [ADDR_W-1:0]                  pkt_end_q, pkt_end_d;
    logic [NUM_HEADERS-1:0][LEN_W-1:0]  len_q, len_d;
    logic [NUM_HEADERS-1:0][TS_W-1:0]   ts_q, ts_d;
    logic [NUM_HEADERS-1:0][TL_W-1:0]   tl_q, tl_d;
    logic [NUM_HEADERS-1:0][TBL_W-1:0]  tbl_q, tbl_d;
    logic                               hit, nid_ok, wr_ok;
    logic [HID_W-1:0]                   nid;
    logic [ADDR_W-1:0]                  next_addr;
    logic                               unused_data;

    assign next_addr   = cur_addr_q + ADDR_W'(len_q[cur_id_q]);
    // Address/width come straight from registered state, so they cannot move while ce is high.
    assign mem_ce_o    = state_q == FETCH && tl_q[cur_id_q] != '0;
    assign mem_addr_o  = cur_addr_q + ADDR_W'(ts_q[cur_id_q]);
    assign mem_width_o = 4'(tl_q[cur_id_q]);
    assign unused_data = ^mem_data_i;

    next_table_match #(
        .NEXT_TABLE_SIZE(NEXT_TABLE_SIZE),
        .TAG_W          (TAG_W),
        .HID_W          (HID_W)
    ) u_match (
        .entries_i(tbl_q[cur_id_q]),
        .tag_i    (tag_q),
        .hit_o    (hit),
        .next_id_o(nid)
    );

    assign nid_ok = id_in_range(32'(nid), NUM_HEADERS);
    assign wr_ok  = id_in_range(32'(mod_hdr_id_i), NUM_HEADERS)
                 && id_in_range(32'(mod_entry_i[ENT_NID_LSB +: HID_W]), NUM_HEADERS)
                 && id_in_range(32'(mod_entry_idx_i), NEXT_TABLE_SIZE);

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        cur_addr_d  = cur_addr_q;
        tag_d       = tag_q;
        ready_d     = ready_q;
        err_d       = err_q;
        mod_ack_d   = 1'b0;
        hdr_valid_d = hdr_valid_q;
        parsed_d    = parsed_q;
        pkt_end_d   = pkt_end_q;
        len_d       = len_q;
        ts_d        = ts_q;
        tl_d        = tl_q;
        tbl_d       = tbl_q;
        case (state_q)
            FREE: begin
                // A config write defers any pending start by one cycle.
                if (mod_start_i) begin
                    if (wr_ok) begin
                        len_d[mod_hdr_id_i] = mod_hdr_len_i;
                        ts_d[mod_hdr_id_i]  = mod_tag_start_i;
                        tl_d[mod_hdr_id_i]  = mod_tag_len_i;
                        tbl_d[mod_hdr_id_i][mod_entry_idx_i*ENT_W +: ENT_W] = mod_entry_i;
                        mod_ack_d = 1'b1;
                    end
                end else if (start_i) begin
                    hdr_valid_d = '0;
                    err_d       = 1'b0;
                    ready_d     = 1'b0;
                    cur_id_d    = '0;
                    cur_addr_d  = pkt_addr_i;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (tl_q[cur_id_q] == '0) begin
                    parsed_d[cur_id_q]    = cur_addr_q;
                    hdr_valid_d[cur_id_q] = 1'b1;
                    pkt_end_d             = next_addr;
                    ready_d               = 1'b1;
                    state_d               = DONE;
                end else if (mem_ack_i) begin
                    tag_d   = mem_data_i[TAG_W-1:0];
                    state_d = MATCH;
                end
            end
            MATCH: begin
                parsed_d[cur_id_q]    = cur_addr_q;
                hdr_valid_d[cur_id_q] = 1'b1;
                cur_addr_d            = next_addr;
                pkt_end_d             = next_addr;
                // Checked after recording, so a self-referencing entry counts as a loop.
                if (hit && nid_ok && hdr_valid_d[nid]) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (hit && nid_ok) begin
                    cur_id_d = nid;
                    state_d  = FETCH;
                end else begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = start_i ? DONE : FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FREE;
            cur_id_q    <= '0;
            cur_addr_q  <= '0;
            tag_q       <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            mod_ack_q   <= 1'b0;
            hdr_valid_q <= '0;
            parsed_q    <= '0;
            pkt_end_q   <= '0;
            len_q       <= '0;
            ts_q        <= '0;
            tl_q        <= '0;
            tbl_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            cur_addr_q  <= cur_addr_d;
            tag_q       <= tag_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            mod_ack_q   <= mod_ack_d;
            hdr_valid_q <= hdr_valid_d;
            parsed_q    <= parsed_d;
            pkt_end_q   <= pkt_end_d;
            len_q       <= len_d;
            ts_q        <= ts_d;
            tl_q        <= tl_d;
            tbl_q       <= tbl_d;
        end
    end

    assign ready_o     = ready_q;
    assign err_o       = err_q;
    assign mod_ack_o   = mod_ack_q;
    assign hdr_valid_o = hdr_valid_q;
    assign pkt_end_o   = pkt_end_q;

    for (genvar g = 0; g < NUM_HEADERS; g++) begin : g_out
        assign parsed_hdrs_o[(NUM_HEADERS-1-g)*ADDR_W +: ADDR_W] = parsed_q[g];
    end

`ifdef PARSER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
    logic        enter_done;

    always_comb begin
        enter_done = state_d == DONE && state_q != DONE;
        pkt_cnt_d  = (enter_done && !(&pkt_cnt_q)) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
        err_cnt_d  = (enter_done && err_d && !(&err_cnt_q)) ? err_cnt_q + 32'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_hdr_parser.sv
// tb_pkt_hdr_parser: scoreboard bench for pkt_hdr_parser with directed header chains.
module tb_pkt_hdr_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] pkt_addr_i = '0;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_width_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic        ready_o;
    logic [127:0] parsed_hdrs_o;
    logic [3:0]  hdr_valid_o;
    logic [31:0] pkt_end_o;
    logic        err_o;
    logic        mod_start_i = 1'b0;
    logic [1:0]  mod_hdr_id_i = '0;
    logic [15:0] mod_hdr_len_i = '0;
    logic [15:0] mod_tag_start_i = '0;
    logic [2:0]  mod_tag_len_i = '0;
    logic [1:0]  mod_entry_idx_i = '0;
    logic [18:0] mod_entry_i = '0;
    logic        mod_ack_o;
`ifdef PARSER_STATS_EN
    logic [31:0] pkt_cnt_o, err_cnt_o;
`endif

    pkt_hdr_parser dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pkt_addr_i(pkt_addr_i),
        .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .ready_o(ready_o),
        .parsed_hdrs_o(parsed_hdrs_o), .hdr_valid_o(hdr_valid_o), .pkt_end_o(pkt_end_o),
        .err_o(err_o), .mod_start_i(mod_start_i), .mod_hdr_id_i(mod_hdr_id_i),
        .mod_hdr_len_i(mod_hdr_len_i), .mod_tag_start_i(mod_tag_start_i),
        .mod_tag_len_i(mod_tag_len_i), .mod_entry_idx_i(mod_entry_idx_i),
        .mod_entry_i(mod_entry_i), .mod_ack_o(mod_ack_o)
`ifdef PARSER_STATS_EN
        , .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] h [4];
        logic [3:0]  v;
        logic [31:0] e;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb [$];
    logic [35:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wait_cyc = 0;

    initial forever #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] h0, h1, h2, h3, input logic [3:0] v,
                                input logic [31:0] e, input logic err, input int lat);
        exp_t x;
        x.h[0] = h0; x.h[1] = h1; x.h[2] = h2; x.h[3] = h3;
        x.v = v; x.e = e; x.err = err; x.lat = lat; x.acc = 0;
        return x;
    endfunction

    // Memory responder: acks after wait_cyc cycles of ce, checks address/width behaviour.
    initial begin
        int          wcnt = 0;
        logic        ce_prev = 1'b0;
        logic [31:0] addr_prev = '0;
        logic [3:0]  width_prev = '0;
        logic [35:0] m;
        forever begin
            @(negedge clk);
            if (mem_ce_o && ce_prev) begin
                chk("mem_addr_stable", 64'(mem_addr_o), 64'(addr_prev));
                chk("mem_width_stable", 64'(mem_width_o), 64'(width_prev));
            end
            if (mem_ce_o) begin
                mem_ack_i = (wcnt == wait_cyc);
                wcnt = mem_ack_i ? 0 : wcnt + 1;
            end else begin
                mem_ack_i = 1'b0;
                wcnt = 0;
            end
            m = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 36'h0;
            mem_data_i = mem_ack_i ? m[31:0] : 32'h0;
            if (mem_ack_i) chk("mem_width", 64'(mem_width_o), 64'(m[35:32]));
            ce_prev = mem_ce_o;
            addr_prev = mem_addr_o;
            width_prev = mem_width_o;
        end
    end

    // Monitor: on each new ready_o, pop the oldest expectation and compare.
    initial begin
        logic rdy_prev = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && ready_o && !rdy_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'(ready_o), 64'(0));
                end else begin
                    x = sb.pop_front();
                    chk("latency", 64'(cyc - x.acc), 64'(x.lat));
                    chk("hdr_valid", 64'(hdr_valid_o), 64'(x.v));
                    chk("pkt_end", 64'(pkt_end_o), 64'(x.e));
                    chk("err", 64'(err_o), 64'(x.err));
                    for (int k = 0; k < 4; k++)
                        if (x.v[k]) chk($sformatf("hdr%0d_addr", k), 64'(parsed_hdrs_o[(3-k)*32 +: 32]), 64'(x.h[k]));
                end
            end
            rdy_prev = ready_o;
        end
    end

    task automatic cfg(input logic [1:0] id, input logic [15:0] len, ts, input logic [2:0] tl,
                       input logic [1:0] idx, input logic v, input logic [15:0] tag, input logic [1:0] nid);
        @(negedge clk);
        mod_hdr_id_i = id; mod_hdr_len_i = len; mod_tag_start_i = ts; mod_tag_len_i = tl;
        mod_entry_idx_i = idx; mod_entry_i = {v, tag, nid}; mod_start_i = 1'b1;
        @(negedge clk);
        mod_start_i = 1'b0;
        chk("mod_ack_pulse", 64'(mod_ack_o), 64'(1));
        @(negedge clk);
        chk("mod_ack_drop", 64'(mod_ack_o), 64'(0));
    endtask

    task automatic run_parse(input logic [31:0] addr, input exp_t ex, input bit poke);
        bit got = 1'b0;
        @(negedge clk);
        pkt_addr_i = addr;
        start_i = 1'b1;
        ex.acc = cyc;
        sb.push_back(ex);
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = ready_o;
        end
        if (!got) chk("ready_timeout", 64'(ready_o), 64'(1));
        if (poke) begin
            // Config write while DONE must be ignored: no ack, no table change.
            mod_hdr_id_i = 2'd0; mod_hdr_len_i = 16'd99; mod_tag_start_i = 16'd0; mod_tag_len_i = 3'd0;
            mod_entry_idx_i = 2'd0; mod_entry_i = {1'b1, 16'h86DD, 2'd3}; mod_start_i = 1'b1;
            @(negedge clk);
            mod_start_i = 1'b0;
            chk("done_cfg_no_ack0", 64'(mod_ack_o), 64'(0));
            @(negedge clk);
            chk("done_cfg_no_ack1", 64'(mod_ack_o), 64'(0));
        end
        start_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'(0));
        chk("rst_ce", 64'(mem_ce_o), 64'(0));
        chk("rst_outs", 64'({hdr_valid_o, err_o, mod_ack_o, pkt_end_o}), 64'(0));
        chk("rst_parsed", 64'(|parsed_hdrs_o), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Two-header chain: Ethernet-like hdr0 -> terminal hdr1.
        cfg(2'd0, 16'd14, 16'd12, 3'd2, 2'd0, 1'b1, 16'h0800, 2'd1);
        cfg(2'd1, 16'd20, 16'd0, 3'd0, 2'd0, 1'b0, 16'h0000, 2'd0);
        mem[32'h10C] = {4'd2, 32'h0800};
        run_parse(32'h100, mk(32'h100, 32'h10E, 0, 0, 4'b0011, 32'h122, 1'b0, 4), 1'b1);

        // Miss on hdr0's tag.
        mem[32'h10C] = {4'd2, 32'h86DD};
        run_parse(32'h100, mk(32'h100, 0, 0, 0, 4'b0001, 32'h10E, 1'b0, 3), 1'b0);

        // Priority: entries 1 and 3 both match, lowest index (next=2) wins.
        cfg(2'd0, 16'd14, 16'd12, 3'd2, 2'd0, 1'b0, 16'h0000, 2'd0);
        cfg(2'd0, 16'd14, 16'd12, 3'd2, 2'd1, 1'b1, 16'h0800, 2'd2);
        cfg(2'd0, 16'd14, 16'd12, 3'd2, 2'd3, 1'b1, 16'h0800, 2'd3);
        cfg(2'd2, 16'd8, 16'd0, 3'd0, 2'd0, 1'b0, 16'h0000, 2'd0);
        mem[32'h10C] = {4'd2, 32'h0800};
        run_parse(32'h100, mk(32'h100, 0, 32'h10E, 0, 4'b0101, 32'h116, 1'b0, 4), 1'b0);

        // Loop: hdr1 points back to hdr0.
        cfg(2'd0, 16'd14, 16'd12, 3'd2, 2'd1, 1'b1, 16'h0800, 2'd1);
        cfg(2'd1, 16'd20, 16'd0, 3'd2, 2'd0, 1'b1, 16'h0001, 2'd0);
        mem[32'h10E] = {4'd2, 32'h0001};
        run_parse(32'h100, mk(32'h100, 32'h10E, 0, 0, 4'b0011, 32'h122, 1'b1, 5), 1'b0);

        // Three wait states on each read of a two tagged-header chain.
        wait_cyc = 3;
        mem[32'h10E] = {4'd2, 32'h1234};
        run_parse(32'h100, mk(32'h100, 32'h10E, 0, 0, 4'b0011, 32'h122, 1'b0, 11), 1'b0);

        // Reset during FETCH aborts at once and wipes config.
        @(negedge clk);
        pkt_addr_i = 32'h100;
        start_i = 1'b1;
        for (int n = 0; n < 20 && !mem_ce_o; n++) @(negedge clk);
        chk("fetch_reached", 64'(mem_ce_o), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ce", 64'(mem_ce_o), 64'(0));
        chk("arst_outs", 64'({ready_o, hdr_valid_o, err_o, mod_ack_o, pkt_end_o}), 64'(0));
        chk("arst_parsed", 64'(|parsed_hdrs_o), 64'(0));
        start_i = 1'b0;
        wait_cyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_parse(32'h200, mk(32'h200, 0, 0, 0, 4'b0001, 32'h200, 1'b0, 2), 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
